// File: rtl/rv32i_mem_stage.sv
// rv32i_mem_stage: registers EX results, issues aligned load/store requests and
// produces extended writeback data, stalling EX while a request is outstanding.
module rv32i_mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid_in,
   input  logic [31:0] alu_in,
   input  logic [31:0] rs2_data_in,
   input  logic [31:0] iw_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic        stall_out,
   output logic        valid_out,
   output logic [31:0] alu_out,
   output logic [31:0] iw_out,
   output logic [31:0] pc_out,
   output logic [4:0]  wb_reg_out,
   output logic        wb_en_out,
   output logic        misalign_out,
   output logic        timeout_out
);
   typedef enum logic {IDLE, WAIT} state_t;
   localparam int CW = $clog2(TIMEOUT + 1);
   state_t st;
   logic [CW-1:0] cnt;
   logic [2:0] f3_r;
   logic [1:0] lo_r;
   logic ld_r;
   logic [6:0] op;
   logic [2:0] f3;
   logic [1:0] lo;
   logic is_ld, is_st, is_mem, mis, wb_op;
   logic [3:0] be;
   logic [31:0] wd, ld_val;
   logic [7:0] byt;
   logic [15:0] half;
   always_comb begin
      op     = iw_in[6:0];
      f3     = iw_in[14:12];
      lo     = alu_in[1:0];
      is_ld  = op == 7'b0000011;
      is_st  = op == 7'b0100011;
      is_mem = is_ld || is_st;
      // funct3[2] is only meaningful (unsigned) for byte/half loads; anything else is undefined
      mis    = (f3[1:0] == 2'b00) ? (is_st && f3[2]) :
               (f3[1:0] == 2'b01) ? (lo[0] || (is_st && f3[2])) :
               (f3 == 3'b010)     ? (lo != 2'b00) : 1'b1;
      be     = (f3[1:0] == 2'b00) ? 4'b0001 << lo :
               (f3[1:0] == 2'b01) ? 4'b0011 << {lo[1], 1'b0} : 4'b1111;
      wd     = (f3[1:0] == 2'b00) ? {4{rs2_data_in[7:0]}} :
               (f3[1:0] == 2'b01) ? {2{rs2_data_in[15:0]}} : rs2_data_in;
      wb_op  = op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
      byt    = mem_rdata[{lo_r, 3'b000} +: 8];
      half   = lo_r[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      ld_val = (f3_r[1:0] == 2'b00) ? {{24{~f3_r[2] & byt[7]}}, byt} :
               (f3_r[1:0] == 2'b01) ? {{16{~f3_r[2] & half[15]}}, half} : mem_rdata;
      stall_out = st == WAIT;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st <= IDLE;
         cnt <= '0;
         f3_r <= '0;
         lo_r <= '0;
         ld_r <= 1'b0;
         mem_req <= 1'b0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         mem_be <= '0;
         valid_out <= 1'b0;
         alu_out <= '0;
         iw_out <= '0;
         pc_out <= '0;
         wb_reg_out <= '0;
         wb_en_out <= 1'b0;
         misalign_out <= 1'b0;
         timeout_out <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         misalign_out <= 1'b0;
         timeout_out <= 1'b0;
         if (st == IDLE) begin
            if (ex_valid_in) begin
               iw_out <= iw_in;
               pc_out <= pc_in;
               wb_reg_out <= iw_in[11:7];
               if (is_mem && !mis) begin
                  st <= WAIT;
                  cnt <= '0;
                  mem_req <= 1'b1;
                  mem_we <= is_st;
                  mem_addr <= {alu_in[31:2], 2'b00};
                  mem_wdata <= wd;
                  mem_be <= be;
                  f3_r <= f3;
                  lo_r <= lo;
                  ld_r <= is_ld;
               end else begin
                  valid_out <= 1'b1;
                  alu_out <= alu_in;
                  misalign_out <= is_mem;
                  wb_en_out <= wb_op && iw_in[11:7] != 5'd0;
               end
            end
         end else if (mem_ack) begin
            st <= IDLE;
            mem_req <= 1'b0;
            valid_out <= 1'b1;
            alu_out <= ld_r ? ld_val : {mem_addr[31:2], lo_r};
            wb_en_out <= ld_r && wb_reg_out != 5'd0;
         end else if (cnt == CW'(TIMEOUT - 1)) begin
            st <= IDLE;
            mem_req <= 1'b0;
            valid_out <= 1'b1;
            timeout_out <= 1'b1;
            alu_out <= '0;
            wb_en_out <= 1'b0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_rv32i_mem_stage.sv
// tb_rv32i_mem_stage: scoreboard bench; expected writeback records are queued
// at issue and compared whenever the DUT pulses valid_out.
module tb_rv32i_mem_stage;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ex_valid_in = 1'b0;
   logic [31:0] alu_in = '0, rs2_data_in = '0, iw_in = '0, pc_in = '0, mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        mem_req, mem_we, stall_out, valid_out, wb_en_out, misalign_out, timeout_out;
   logic [31:0] mem_addr, mem_wdata, alu_out, iw_out, pc_out;
   logic [3:0]  mem_be;
   logic [4:0]  wb_reg_out;
   int checks = 0, errors = 0;
   typedef struct packed {
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        wb, mis, to;
   } exp_t;
   exp_t q[$];
   localparam logic [6:0] OP = 7'b0110011, LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011;

   rv32i_mem_stage #(.TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .ex_valid_in(ex_valid_in), .alu_in(alu_in),
      .rs2_data_in(rs2_data_in), .iw_in(iw_in), .pc_in(pc_in), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .stall_out(stall_out), .valid_out(valid_out),
      .alu_out(alu_out), .iw_out(iw_out), .pc_out(pc_out), .wb_reg_out(wb_reg_out),
      .wb_en_out(wb_en_out), .misalign_out(misalign_out), .timeout_out(timeout_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
      return {17'b0, f3, rd, op};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] iw, input logic [31:0] a, input logic [31:0] d, input exp_t e, input bit push);
      iw_in = iw;
      alu_in = a;
      rs2_data_in = d;
      pc_in = a ^ 32'h1000;
      ex_valid_in = 1'b1;
      if (push) q.push_back(e);
      tick();
      ex_valid_in = 1'b0;
   endtask

   task automatic ack_on(input int n, input logic [31:0] rd);
      repeat (n - 1) tick();
      mem_rdata = rd;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
   endtask

   always @(negedge clk) begin
      if (reset && valid_out) begin
         if (q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = q.pop_front();
            check("alu_out", alu_out, e.alu);
            check("wb_reg", 32'(wb_reg_out), 32'(e.rd));
            check("wb_en", 32'(wb_en_out), 32'(e.wb));
            check("misalign", 32'(misalign_out), 32'(e.mis));
            check("timeout", 32'(timeout_out), 32'(e.to));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n;
      #12;
      check("rst_valid", 32'(valid_out), 0);
      check("rst_req", 32'(mem_req), 0);
      check("rst_stall", 32'(stall_out), 0);
      check("rst_alu", alu_out, 0);
      #10 reset = 1'b1;
      tick();
      issue(mk(OP, 3'b000, 5'd5), 32'h32000000, 0, '{32'h32000000, 5'd5, 1'b1, 1'b0, 1'b0}, 1);
      check("add_lat", 32'(valid_out), 1);
      check("add_noreq", 32'(mem_req), 0);
      issue(mk(OP, 3'b000, 5'd0), 32'h00000011, 0, '{32'h00000011, 5'd0, 1'b0, 1'b0, 1'b0}, 1);
      issue(mk(BR, 3'b000, 5'd9), 32'h00000022, 0, '{32'h00000022, 5'd9, 1'b0, 1'b0, 1'b0}, 1);
      tick();
      issue(mk(ST, 3'b000, 5'd3), 32'h02000456, 32'h000000AB, '{32'h02000456, 5'd3, 1'b0, 1'b0, 1'b0}, 1);
      check("sb_req", 32'(mem_req), 1);
      check("sb_we", 32'(mem_we), 1);
      check("sb_be", 32'(mem_be), 32'h4);
      check("sb_wdata", mem_wdata, 32'hABABABAB);
      check("sb_addr", mem_addr, 32'h02000454);
      check("sb_stall", 32'(stall_out), 1);
      ack_on(1, 0);
      check("sb_lat2", 32'(valid_out), 1);
      check("sb_req_drop", 32'(mem_req), 0);
      issue(mk(ST, 3'b001, 5'd4), 32'h00000102, 32'h12345678, '{32'h00000102, 5'd4, 1'b0, 1'b0, 1'b0}, 1);
      check("sh_be", 32'(mem_be), 32'hC);
      check("sh_wdata", mem_wdata, 32'h56785678);
      ack_on(2, 0);
      issue(mk(LD, 3'b000, 5'd7), 32'h00000203, 0, '{32'hFFFFFF80, 5'd7, 1'b1, 1'b0, 1'b0}, 1);
      check("lb_we", 32'(mem_we), 0);
      check("lb_addr", mem_addr, 32'h00000200);
      ack_on(3, 32'h80FFFFFF);
      issue(mk(LD, 3'b100, 5'd7), 32'h00000203, 0, '{32'h00000080, 5'd7, 1'b1, 1'b0, 1'b0}, 1);
      ack_on(3, 32'h80FFFFFF);
      issue(mk(LD, 3'b001, 5'd8), 32'h00000302, 0, '{32'hFFFF8001, 5'd8, 1'b1, 1'b0, 1'b0}, 1);
      ack_on(1, 32'h80011234);
      issue(mk(LD, 3'b101, 5'd8), 32'h00000300, 0, '{32'h00001234, 5'd8, 1'b1, 1'b0, 1'b0}, 1);
      ack_on(1, 32'h80011234);
      issue(mk(LD, 3'b010, 5'd0), 32'h00000100, 0, '{32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b0}, 1);
      ack_on(1, 32'hDEADBEEF);
      issue(mk(ST, 3'b010, 5'd1), 32'h00000002, 32'h55, '{32'h00000002, 5'd1, 1'b0, 1'b1, 1'b0}, 1);
      check("sw_mis_req", 32'(mem_req), 0);
      check("sw_mis_stall", 32'(stall_out), 0);
      issue(mk(LD, 3'b001, 5'd2), 32'h00000001, 0, '{32'h00000001, 5'd2, 1'b0, 1'b1, 1'b0}, 1);
      issue(mk(LD, 3'b011, 5'd2), 32'h00000000, 0, '{32'h00000000, 5'd2, 1'b0, 1'b1, 1'b0}, 1);
      issue(mk(LD, 3'b010, 5'd6), 32'h00000400, 0, '{32'h00000000, 5'd6, 1'b0, 1'b0, 1'b1}, 1);
      n = 0;
      while (mem_req && n < 40) begin
         n++;
         tick();
      end
      check("to_req_cycles", 32'(n), 16);
      issue(mk(LD, 3'b010, 5'd6), 32'h00000400, 0, '{32'hCAFEF00D, 5'd6, 1'b1, 1'b0, 1'b0}, 1);
      ack_on(16, 32'hCAFEF00D);
      check("ack16_wins", 32'(valid_out), 1);
      issue(mk(LD, 3'b010, 5'd6), 32'h00000500, 0, '0, 0);
      tick();
      #2 reset = 1'b0;
      #1;
      check("arst_req", 32'(mem_req), 0);
      check("arst_stall", 32'(stall_out), 0);
      #3 reset = 1'b1;
      tick();
      mem_ack = 1'b1;
      mem_rdata = 32'h12121212;
      tick();
      mem_ack = 1'b0;
      check("late_ack_valid", 32'(valid_out), 0);
      check("late_ack_req", 32'(mem_req), 0);
      tick();
      check("queue_empty", 32'(q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
